// File: rtl/proc_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : proc_hazard_unit
// Purpose  : Stall / squash / bypass controller for an in-order pipeline with
//            NSTAGES post-decode stages. Optional perf counters are enabled
//            by defining PROC_HAZARD_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module proc_hazard_unit #(
  parameter int NSTAGES  = 3,
  parameter int NREGS    = 32,
  parameter int MAX_XLAT = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           val_D,
  input  logic                           rs1_en_D,
  input  logic                           rs2_en_D,
  input  logic [$clog2(NREGS)-1:0]       rs1_D,
  input  logic [$clog2(NREGS)-1:0]       rs2_D,
  input  logic [$clog2(NREGS)-1:0]       rd_D,
  input  logic                           wen_D,
  input  logic [$clog2(NSTAGES+1)-1:0]   avail_D,
  input  logic [$clog2(MAX_XLAT+1)-1:0]  xlat_D,
  input  logic                           redirect_D,
  input  logic                           redirect_X,
  input  logic                           mem_wait,
  output logic                           reg_en_F,
  output logic                           reg_en_D,
  output logic                           reg_en_X,
  output logic                           squash_F,
  output logic                           squash_D,
  output logic [$clog2(NSTAGES+1)-1:0]   op1_byp_sel_D,
  output logic [$clog2(NSTAGES+1)-1:0]   op2_byp_sel_D,
  output logic                           x_busy,
  output logic [31:0]                    stall_cnt,
  output logic [31:0]                    squash_cnt
);

  localparam int c_aw = $clog2(NREGS);
  localparam int c_sw = $clog2(NSTAGES+1);
  localparam int c_lw = $clog2(MAX_XLAT+1);

  // In-flight entries: index 1 = X ... NSTAGES = W
  logic [NSTAGES:1]  r_val;
  logic [NSTAGES:1]  r_wen;
  logic [c_aw-1:0]   r_rd    [1:NSTAGES];
  logic [c_sw-1:0]   r_avail [1:NSTAGES];
  logic [c_lw-1:0]   r_xcnt;

  logic [NSTAGES:1]  w_match1;
  logic [NSTAGES:1]  w_match2;
  logic [c_sw-1:0]   w_sel1;
  logic [c_sw-1:0]   w_sel2;
  logic              w_raw1;
  logic              w_raw2;
  logic              w_hit1;
  logic              w_hit2;

  // Asserted reset masks the request inputs so outputs show their idle values
  logic w_val_D;
  logic w_freeze;
  logic w_hold_X;
  logic w_stall_D;
  logic w_squash_D;
  logic w_accept;

  assign w_val_D  = val_D & rst;
  assign w_freeze = mem_wait & rst;
  assign w_hold_X = (r_xcnt != '0);

  genvar gk;
  generate
    for (gk = 1; gk <= NSTAGES; gk++) begin : g_match
      assign w_match1[gk] = r_val[gk] & r_wen[gk] & (r_rd[gk] == rs1_D) & (r_rd[gk] != '0);
      assign w_match2[gk] = r_val[gk] & r_wen[gk] & (r_rd[gk] == rs2_D) & (r_rd[gk] != '0);
    end
  endgenerate

  // Only the youngest (lowest-index) matching producer decides the outcome
  always_comb begin
    w_sel1 = '0;
    w_sel2 = '0;
    w_raw1 = 1'b0;
    w_raw2 = 1'b0;
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int k = 1; k <= NSTAGES; k++) begin
      if (!w_hit1 && w_match1[k]) begin
        w_hit1 = 1'b1;
        if (r_avail[k] <= c_sw'(k)) w_sel1 = c_sw'(k);
        else                        w_raw1 = 1'b1;
      end
      if (!w_hit2 && w_match2[k]) begin
        w_hit2 = 1'b1;
        if (r_avail[k] <= c_sw'(k)) w_sel2 = c_sw'(k);
        else                        w_raw2 = 1'b1;
      end
    end
  end

  assign w_stall_D  = w_val_D & ((rs1_en_D & w_raw1) | (rs2_en_D & w_raw2));
  assign w_squash_D = redirect_X & rst & ~w_freeze & ~w_hold_X;
  assign w_accept   = w_val_D & ~w_stall_D & ~w_squash_D;

  assign op1_byp_sel_D = (w_val_D & rs1_en_D) ? w_sel1 : '0;
  assign op2_byp_sel_D = (w_val_D & rs2_en_D) ? w_sel2 : '0;

  // A squash in X overrides a pending load-use stall in D
  assign reg_en_X = ~(w_freeze | w_hold_X);
  assign reg_en_D = ~(w_freeze | w_hold_X | (w_stall_D & ~w_squash_D));
  assign reg_en_F = reg_en_D;
  assign squash_D = w_squash_D;
  assign squash_F = w_squash_D |
                    (w_val_D & redirect_D & ~w_stall_D & ~w_freeze & ~w_hold_X);
  assign x_busy   = w_hold_X;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val  <= '0;
      r_wen  <= '0;
      r_xcnt <= '0;
      for (int k = 1; k <= NSTAGES; k++) begin
        r_rd[k]    <= '0;
        r_avail[k] <= '0;
      end
    end else if (!w_freeze) begin
      for (int k = 2; k <= NSTAGES; k++) begin
        r_val[k]   <= (w_hold_X && k == 2) ? 1'b0 : r_val[k-1];
        r_wen[k]   <= r_wen[k-1];
        r_rd[k]    <= r_rd[k-1];
        r_avail[k] <= r_avail[k-1];
      end
      if (w_hold_X) begin
        r_xcnt <= r_xcnt - c_lw'(1);
      end else begin
        r_val[1]   <= w_accept;
        r_wen[1]   <= wen_D;
        r_rd[1]    <= rd_D;
        r_avail[1] <= avail_D;
        r_xcnt     <= (w_accept && xlat_D > c_lw'(1)) ? xlat_D - c_lw'(1) : '0;
      end
    end
  end

`ifdef PROC_HAZARD_PERF_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_squash_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt  <= '0;
      r_squash_cnt <= '0;
    end else begin
      if (!reg_en_D && r_stall_cnt != 32'hFFFF_FFFF)
        r_stall_cnt <= r_stall_cnt + 32'd1;
      if ((squash_D || squash_F) && r_squash_cnt != 32'hFFFF_FFFF)
        r_squash_cnt <= r_squash_cnt + 32'd1;
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign squash_cnt = r_squash_cnt;
`else
  assign stall_cnt  = '0;
  assign squash_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_proc_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_hazard_unit
// Purpose  : Directed bench for proc_hazard_unit (NSTAGES=3, X=1 M=2 W=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       val_D, rs1_en_D, rs2_en_D, wen_D, redirect_D, redirect_X, mem_wait;
  logic [4:0] rs1_D, rs2_D, rd_D;
  logic [1:0] avail_D;
  logic [3:0] xlat_D;
  logic       reg_en_F, reg_en_D, reg_en_X, squash_F, squash_D, x_busy;
  logic [1:0] op1_byp_sel_D, op2_byp_sel_D;
  logic [31:0] stall_cnt, squash_cnt;
  logic [31:0] sq_before;

  int n_tests = 0;
  int n_fail  = 0;

  proc_hazard_unit #(.NSTAGES(3), .NREGS(32), .MAX_XLAT(8)) dut (
    .clk(clk), .rst(rst),
    .val_D(val_D), .rs1_en_D(rs1_en_D), .rs2_en_D(rs2_en_D),
    .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D), .wen_D(wen_D),
    .avail_D(avail_D), .xlat_D(xlat_D),
    .redirect_D(redirect_D), .redirect_X(redirect_X), .mem_wait(mem_wait),
    .reg_en_F(reg_en_F), .reg_en_D(reg_en_D), .reg_en_X(reg_en_X),
    .squash_F(squash_F), .squash_D(squash_D),
    .op1_byp_sel_D(op1_byp_sel_D), .op2_byp_sel_D(op2_byp_sel_D),
    .x_busy(x_busy), .stall_cnt(stall_cnt), .squash_cnt(squash_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the D-stage instruction fields
  task automatic drv(input logic v, input logic e1, input logic [4:0] s1,
                     input logic e2, input logic [4:0] s2,
                     input logic w, input logic [4:0] d,
                     input logic [1:0] av, input logic [3:0] xl);
    val_D = v; rs1_en_D = e1; rs1_D = s1; rs2_en_D = e2; rs2_D = s2;
    wen_D = w; rd_D = d; avail_D = av; xlat_D = xl;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; redirect_D = 1'b0; redirect_X = 1'b0; mem_wait = 1'b0;
    drv(1, 1, 5'd1, 1, 5'd2, 1, 5'd1, 2'd1, 4'd1);
    repeat (2) cyc();
    #1;
    chk("rst_reg_en_F", reg_en_F, 1); chk("rst_reg_en_D", reg_en_D, 1);
    chk("rst_reg_en_X", reg_en_X, 1); chk("rst_squash_F", squash_F, 0);
    chk("rst_squash_D", squash_D, 0); chk("rst_sel1", op1_byp_sel_D, 0);
    chk("rst_sel2", op2_byp_sel_D, 0); chk("rst_x_busy", x_busy, 0);
    chk("rst_stall_cnt", stall_cnt, 0); chk("rst_squash_cnt", squash_cnt, 0);

    // ADDI x1 -> ADD reads x1
    cyc(); rst = 1'b1; drv(1, 0, 5'd0, 0, 5'd0, 1, 5'd1, 2'd1, 4'd1);
    #1 chk("addi_reg_en_D", reg_en_D, 1);
    cyc(); drv(1, 1, 5'd1, 1, 5'd0, 1, 5'd5, 2'd1, 4'd1);
    #1 chk("alu_byp_sel1", op1_byp_sel_D, 1); chk("alu_byp_sel2_x0", op2_byp_sel_D, 0);
    chk("alu_no_stall", reg_en_D, 1);
    // LW x2 in X; rs2 reads x1 now in M
    cyc(); drv(1, 1, 5'd0, 1, 5'd1, 1, 5'd2, 2'd2, 4'd1);
    #1 chk("m_byp_sel2", op2_byp_sel_D, 2);
    // load-use: one stall, x1 now in W
    cyc(); drv(1, 1, 5'd2, 1, 5'd1, 0, 5'd0, 2'd1, 4'd1);
    #1 chk("lu_reg_en_D", reg_en_D, 0); chk("lu_reg_en_F", reg_en_F, 0);
    chk("lu_reg_en_X", reg_en_X, 1); chk("w_byp_sel2", op2_byp_sel_D, 3);
    cyc();
    #1 chk("lu_after_sel1", op1_byp_sel_D, 2); chk("lu_after_reg_en_D", reg_en_D, 1);
    chk("retired_sel2", op2_byp_sel_D, 0);

    // x3 writers in X and W -> youngest wins
    cyc(); drv(1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 2'd1, 4'd1);
    cyc(); drv(1, 0, 5'd0, 0, 5'd0, 1, 5'd4, 2'd1, 4'd1);
    cyc(); drv(1, 0, 5'd0, 0, 5'd0, 1, 5'd3, 2'd1, 4'd1);
    cyc(); drv(1, 1, 5'd3, 1, 5'd4, 0, 5'd0, 2'd1, 4'd1);
    #1 chk("youngest_sel1", op1_byp_sel_D, 1); chk("youngest_sel2", op2_byp_sel_D, 2);
    val_D = 1'b0;
    #1 chk("inval_sel1", op1_byp_sel_D, 0); chk("inval_sel2", op2_byp_sel_D, 0);
    cyc(); drv(1, 0, 5'd0, 0, 5'd0, 1, 5'd0, 2'd1, 4'd1);
    cyc(); drv(1, 1, 5'd0, 1, 5'd3, 0, 5'd0, 2'd1, 4'd1);
    #1 chk("rd0_sel1", op1_byp_sel_D, 0); chk("w_x3_sel2", op2_byp_sel_D, 3);

    // MUL x6, xlat=4
    cyc(); drv(1, 0, 5'd0, 0, 5'd0, 1, 5'd6, 2'd2, 4'd4);
    #1 chk("mul_enter_busy", x_busy, 0); chk("mul_enter_reg_en_D", reg_en_D, 1);
    cyc(); drv(1, 1, 5'd6, 0, 5'd0, 1, 5'd7, 2'd1, 4'd1);
    #1 chk("mul_busy1", x_busy, 1); chk("mul_reg_en_X", reg_en_X, 0);
    chk("mul_reg_en_D", reg_en_D, 0); chk("mul_reg_en_F", reg_en_F, 0);
    cyc(); #1 chk("mul_busy2", x_busy, 1);
    cyc(); #1 chk("mul_busy3", x_busy, 1); chk("mul_busy3_reg_en_X", reg_en_X, 0);
    cyc(); #1 chk("mul_done_busy", x_busy, 0); chk("mul_dep_stall", reg_en_D, 0);
    chk("mul_done_reg_en_X", reg_en_X, 1); chk("mul_dep_sel_wait", op1_byp_sel_D, 0);
    cyc(); #1 chk("mul_dep_sel", op1_byp_sel_D, 2); chk("mul_dep_go", reg_en_D, 1);

    // redirect_X against a pending load-use stall
    cyc(); drv(1, 0, 5'd0, 0, 5'd0, 1, 5'd8, 2'd2, 4'd1);
    cyc(); drv(1, 1, 5'd8, 0, 5'd0, 1, 5'd9, 2'd1, 4'd1);
    #1 chk("pre_redir_stall", reg_en_D, 0);
    sq_before = squash_cnt;
    redirect_X = 1'b1;
    #1 chk("redir_squash_D", squash_D, 1); chk("redir_squash_F", squash_F, 1);
    chk("redir_no_stall", reg_en_D, 1); chk("redir_reg_en_F", reg_en_F, 1);
    cyc(); redirect_X = 1'b0; redirect_D = 1'b1;
    drv(1, 1, 5'd8, 1, 5'd9, 1, 5'd10, 2'd1, 4'd1);
    #1 chk("post_redir_sel1", op1_byp_sel_D, 2); chk("squashed_not_in_X", op2_byp_sel_D, 0);
    chk("redirD_squash_F", squash_F, 1); chk("redirD_squash_D", squash_D, 0);
`ifdef PROC_HAZARD_PERF_EN
    chk("squash_cnt_inc", squash_cnt, sq_before + 32'd1);
`else
    chk("squash_cnt_tied", squash_cnt, 0); chk("stall_cnt_tied", stall_cnt, 0);
`endif

    // mem_wait freeze with x8 in W, x10 in X
    cyc(); redirect_D = 1'b0; mem_wait = 1'b1;
    drv(1, 1, 5'd8, 1, 5'd10, 0, 5'd0, 2'd1, 4'd1);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("frz_reg_en_F", reg_en_F, 0); chk("frz_reg_en_D", reg_en_D, 0);
      chk("frz_reg_en_X", reg_en_X, 0);
      chk("frz_sel1", op1_byp_sel_D, 3); chk("frz_sel2", op2_byp_sel_D, 1);
      if (i == 2) begin
        redirect_X = 1'b1;
        #1 chk("frz_no_squash_D", squash_D, 0); chk("frz_no_squash_F", squash_F, 0);
        redirect_X = 1'b0;
      end
      cyc();
    end
    #1 chk("frz_hold_sel1", op1_byp_sel_D, 3);
    rst = 1'b0;
    #1 chk("rst_frz_sel1", op1_byp_sel_D, 0); chk("rst_frz_sel2", op2_byp_sel_D, 0);
    chk("rst_frz_reg_en_D", reg_en_D, 1); chk("rst_frz_reg_en_X", reg_en_X, 1);
    cyc(); rst = 1'b1; mem_wait = 1'b0;
    #1 chk("post_rst_sel1", op1_byp_sel_D, 0); chk("post_rst_sel2", op2_byp_sel_D, 0);

    // reset while a multi-cycle op holds X
    cyc(); drv(1, 0, 5'd0, 0, 5'd0, 1, 5'd11, 2'd2, 4'd3);
    cyc(); val_D = 1'b0;
    #1 chk("hold2_busy", x_busy, 1);
    rst = 1'b0;
    #1 chk("rst_hold_busy", x_busy, 0);
    cyc(); rst = 1'b1;
    #1 chk("after_rst_busy", x_busy, 0); chk("after_rst_reg_en_X", reg_en_X, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/proc_hazard_unit.md
Name: proc_hazard_unit

Overview:
- Parametrised hazard controller for the in-order TinyRV1 pipeline, generalised to NSTAGES post-decode stages.
- Tracks in-flight destination registers in an internal per-stage shift register (X = stage 1 … W = stage NSTAGES).
- Drives stall, squash and bypass selects, including support for variable-latency X-stage ops (iterative multiply) and a global memory-wait freeze.
- Sits inside the processor control unit and replaces its hard-coded X/M/W stall/bypass logic.

Parameters:
- NSTAGES, 3, number of stages after D (min 2); stage k = 1..NSTAGES.
- NREGS, 32, architectural registers; register 0 is hardwired zero.
- MAX_XLAT, 8, maximum X-stage occupancy in cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- val_D  in  1  valid instruction in D.
- rs1_en_D / rs2_en_D  in  1  D reads rs1 / rs2.
- rs1_D / rs2_D / rd_D  in  $clog2(NREGS)  source and destination addresses.
- wen_D  in  1  D writes rd.
- avail_D  in  $clog2(NSTAGES+1)  earliest stage whose output carries the result (ALU=1, LW=2, MUL=2).
- xlat_D  in  $clog2(MAX_XLAT+1)  X occupancy in cycles, 1..MAX_XLAT.
- redirect_D  in  1  JAL/JR in D.
- redirect_X  in  1  taken branch resolving in X.
- mem_wait  in  1  dmem not ready; global freeze.
- reg_en_F / reg_en_D / reg_en_X  out  1  stage advance enables.
- squash_F / squash_D  out  1  kill the F / D instruction.
- op1_byp_sel_D / op2_byp_sel_D  out  $clog2(NSTAGES+1)  0 = RF; k = bypass from stage k.
- x_busy  out  1  multi-cycle op holding X.
- stall_cnt / squash_cnt  out  32  perf counters (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): all entries invalid, xcnt=0, counters=0.
  - Outputs in reset: reg_en_*=1, squash_*=0, byp_sel=0, x_busy=0.
- Entry per stage: {val, wen, rd, avail}.
- freeze = mem_wait.
- hold_X = (xcnt != 0).
- Entering X with xlat_D = L > 1 loads xcnt = L-1. xcnt decrements each non-frozen cycle.
- x_busy = hold_X.
- Bypass match for source rs at stage k: val & wen & (rd == rs) & (rd != 0).
  - Only the youngest match (smallest k) is considered.
  - If its avail <= k: sel = k. Otherwise raw_stall.
  - No match: sel = 0.
  - Selects are forced to 0 when the source is not enabled or val_D = 0.
- stall_D = val_D & raw_stall (either operand).
- Priority: freeze > hold_X > stall_D.
  - freeze: every register holds, including the W entry; reg_en_F/D/X = 0.
  - hold_X: X entry holds; a bubble enters stage 2; reg_en_F = reg_en_D = reg_en_X = 0.
  - stall_D: X advances; a bubble enters X; reg_en_F = reg_en_D = 0.
- Effective redirect_X = redirect_X & ~freeze & ~hold_X.
  - squash_D = effective redirect_X.
  - squash_F = squash_D | (val_D & redirect_D & ~stall_D & ~freeze & ~hold_X).
  - A squashed D produces a bubble in X.
- Advance (no freeze, no hold_X): stage k+1 <= stage k.
  - Stage 1 <= D info if val_D & ~stall_D & ~squash_D, else invalid.
  - The W entry retires.
- Simultaneous redirect_X and stall_D: squash wins; no stall; bubble into X.
- Reset mid-hold clears xcnt immediately.

Optional Feature:
- Macro PROC_HAZARD_PERF_EN.
- When defined:
  - stall_cnt increments each cycle reg_en_D = 0.
  - squash_cnt increments each cycle squash_D | squash_F.
  - Both are 32-bit, saturate at 32'hFFFFFFFF, and clear on reset.
- When undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- ADDI x1 (avail=1) in X, then ADD reading x1 in D -> op1_byp_sel_D=1, stall_D=0.
- LW x2 (avail=2) in X, D reads x2 -> one stall cycle (reg_en_D=0); next cycle op sel=2.
- Writers to x3 in X (avail=1) and W (avail=1), D reads x3 -> sel=1 (youngest wins). Writer rd=0 -> sel=0.
- MUL with xlat=4 -> x_busy high for 3 cycles, reg_en_X=0, bubbles reach stage 2; a dependent op then gets sel=2.
- redirect_X together with a pending load-use stall -> squash_D=1, squash_F=1, stall_D=0, X invalid next cycle. With PROC_HAZARD_PERF_EN, squash_cnt increments by 1.
- mem_wait high 5 cycles with an entry in W -> all entries unchanged, reg_en_*=0; rst pulse mid-freeze -> all invalid, sel=0.
